// File: rtl/invaders_grid_pkg.sv
// Shared types and defaults for the invader grid block.
package invaders_grid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARCH = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    localparam int DEF_COLS      = 10;
    localparam int DEF_ROWS      = 3;
    localparam int DEF_X_W       = 5;
    localparam int DEF_Y_W       = 4;
    localparam int DEF_TICK_DIV  = 1;
    localparam int DEF_LAND_LINE = 14;
    localparam int LEVEL_W       = 3;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/invaders_grid_if.sv
// Player-side control, bullet probe and grid status bundle.
interface invaders_grid_if
    import invaders_grid_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int X_W  = DEF_X_W,
    parameter int Y_W  = DEF_Y_W
) ();
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);

    logic                   start;
    logic [LEVEL_W-1:0]     level;
    logic                   bullet_valid;
    logic [X_W-1:0]         bullet_x;
    logic [Y_W-1:0]         bullet_y;
    logic                   hit;
    logic [RW-1:0]          hit_row;
    logic [CW-1:0]          hit_col;
    logic [ROWS*COLS-1:0]   invaders_array;
    logic [X_W-1:0]         invaders_x;
    logic [Y_W-1:0]         invaders_line;
    logic                   running;
    logic                   cleared;
    logic                   landed;

    modport master (
        output start, level, bullet_valid, bullet_x, bullet_y,
        input  hit, hit_row, hit_col, invaders_array, invaders_x, invaders_line,
               running, cleared, landed
    );

    modport slave (
        input  start, level, bullet_valid, bullet_x, bullet_y,
        output hit, hit_row, hit_col, invaders_array, invaders_x, invaders_line,
               running, cleared, landed
    );

endinterface

// File: rtl/invaders_tick.sv
// Base tick divider and level-dependent step pacing for the marching grid.
module invaders_tick
    import invaders_grid_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic               clk_36MHz,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic [LEVEL_W-1:0] i_level,
    output logic               o_step
);
    localparam int DW = idx_w(TICK_DIV);

    logic [DW-1:0]      r_div;
    logic [LEVEL_W-1:0] r_ticks;
    logic               w_tick;
    logic               w_last;

    assign w_tick = i_en && (r_div == DW'(TICK_DIV - 1));
    // Level 7 steps on every tick, level 0 on every eighth.
    assign w_last = (r_ticks == ('1 - i_level));
    assign o_step = w_tick && w_last;

    // Divider and tick counter only advance while marching.
    always_ff @(posedge clk_36MHz) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset || i_clear) begin
            r_div   <= '0;
            r_ticks <= '0;
        end else if (i_en) begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_ticks <= w_last ? '0 : r_ticks + 1'b1;
            end
        end
    end

endmodule

// File: rtl/invaders_grid.sv
// Invader formation: marching position, alive flags, bullet hit test and wave FSM.
module invaders_grid
    import invaders_grid_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int LAND_LINE = DEF_LAND_LINE
) (
    input  logic           clk_36MHz,
    input  logic           reset,
    invaders_grid_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    localparam int IW = idx_w(N);
    // Leftmost column value at which the right edge of the grid touches the screen edge.
    localparam logic [X_W-1:0] X_RIGHT  = X_W'((1 << X_W) - COLS);
    localparam logic [X_W:0]   COLS_X   = (X_W + 1)'(COLS);
    localparam logic [Y_W:0]   ROWS_Y   = (Y_W + 1)'(ROWS);
    // Top-row line at which the bottom row sits on the landing line.
    localparam logic [Y_W-1:0] LAND_TOP = Y_W'(LAND_LINE - ROWS + 1);

    if (!(COLS <= (1 << X_W) && ROWS <= LAND_LINE && LAND_LINE < (1 << Y_W))) begin : g_bad_params
        $error("invaders_grid: grid does not fit the screen coordinate ranges");
    end

    state_t             r_state;
    state_t             w_state_next;
    dir_t               r_dir;
    dir_t               w_dir_next;
    logic [X_W-1:0]     r_x;
    logic [X_W-1:0]     w_x_next;
    logic [Y_W-1:0]     r_line;
    logic [Y_W-1:0]     w_line_next;
    logic [N-1:0]       r_array;
    logic [N-1:0]       w_array_next;
    logic [LEVEL_W-1:0] r_level;
    logic               r_hit;
    logic [RW-1:0]      r_hit_row;
    logic [CW-1:0]      r_hit_col;

    logic               w_in_march;
    logic               w_start_ok;
    logic               w_step;
    logic [X_W:0]       w_dx;
    logic [Y_W:0]       w_dy;
    logic               w_in_grid;
    logic [RW-1:0]      w_row;
    logic [CW-1:0]      w_col;
    logic [IW-1:0]      w_idx;
    logic               w_hit;
    logic               w_win;
    logic               w_land;

    assign w_in_march = (r_state == ST_MARCH);
    assign w_start_ok = bus.start && !w_in_march;

    invaders_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_36MHz (clk_36MHz),
        .reset     (reset),
        .i_clear   (w_start_ok),
        .i_en      (w_in_march),
        .i_level   (r_level),
        .o_step    (w_step)
    );

    // Bullet offset from the grid origin; always taken from the current (pre-step) position.
    assign w_dx      = {1'b0, bus.bullet_x} - {1'b0, r_x};
    assign w_dy      = {1'b0, bus.bullet_y} - {1'b0, r_line};
    assign w_in_grid = (bus.bullet_x >= r_x) && (w_dx < COLS_X) &&
                       (bus.bullet_y >= r_line) && (w_dy < ROWS_Y);
    assign w_row     = w_dy[RW-1:0];
    assign w_col     = w_dx[CW-1:0];
    assign w_idx     = IW'(w_row) * IW'(COLS) + IW'(w_col);
    assign w_hit     = w_in_march && bus.bullet_valid && w_in_grid && r_array[w_idx];

    // Alive flags after this cycle's hit, if any.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_array_next = r_array;
        if (w_hit) begin
            w_array_next[w_idx] = 1'b0;
        end
    end

    // Horizontal march with a one-line descent at either screen edge.
    always_comb begin
        w_x_next    = r_x;
        w_line_next = r_line;
        w_dir_next  = r_dir;
        if (w_step) begin
            if (r_dir == DIR_RIGHT) begin
                if (r_x == X_RIGHT) begin
                    w_line_next = r_line + 1'b1;
                    w_dir_next  = DIR_LEFT;
                end else begin
                    w_x_next = r_x + 1'b1;
                end
            end else begin
                if (r_x == '0) begin
                    w_line_next = r_line + 1'b1;
                    w_dir_next  = DIR_RIGHT;
                end else begin
                    w_x_next = r_x - 1'b1;
                end
            end
        end
    end

    assign w_win  = w_hit && (w_array_next == '0);
    assign w_land = w_step && (w_line_next == LAND_TOP);

    // Wave FSM next state; clearing the grid wins over a same-cycle landing.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (bus.start) begin
                    w_state_next = ST_MARCH;
                end
            end
            ST_MARCH: begin
                if (w_win) begin
                    w_state_next = ST_WIN;
                end else if (w_land) begin
                    w_state_next = ST_LOSE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Wave FSM state register.
    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grid position, alive flags and hit report; frozen outside MARCH.
    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            // NOTE: the alive flags are plain flops, not a RAM, so they take a reset value like any register.
            r_array   <= '1;
            r_x       <= '0;
            r_line    <= '0;
            r_dir     <= DIR_RIGHT;
            r_level   <= '0;
            r_hit     <= 1'b0;
            r_hit_row <= '0;
            r_hit_col <= '0;
        end else begin
            r_hit <= 1'b0;
            if (w_start_ok) begin
                r_array <= '1;
                r_x     <= '0;
                r_line  <= '0;
                r_dir   <= DIR_RIGHT;
                r_level <= bus.level;
            end else if (w_in_march) begin
                r_array <= w_array_next;
                r_x     <= w_x_next;
                r_line  <= w_line_next;
                r_dir   <= w_dir_next;
                if (w_hit) begin
                    r_hit     <= 1'b1;
                    r_hit_row <= w_row;
                    r_hit_col <= w_col;
                end
            end
        end
    end

    assign bus.hit            = r_hit;
    assign bus.hit_row        = r_hit_row;
    assign bus.hit_col        = r_hit_col;
    assign bus.invaders_array = r_array;
    assign bus.invaders_x     = r_x;
    assign bus.invaders_line  = r_line;
    assign bus.running        = (r_state == ST_MARCH);
    assign bus.cleared        = (r_state == ST_WIN);
    assign bus.landed         = (r_state == ST_LOSE);

endmodule

// File: tb/tb_invaders_grid.sv
// Self-checking bench for invaders_grid: directed vector table, corner sequences, random run vs model.
module tb_invaders_grid;

    localparam int COLS      = 10;
    localparam int ROWS      = 3;
    localparam int X_W       = 5;
    localparam int Y_W       = 4;
    localparam int TICK_DIV  = 1;
    localparam int LAND_LINE = 14;
    localparam int N         = ROWS * COLS;
    localparam int M_IDLE  = 0;
    localparam int M_MARCH = 1;
    localparam int M_WIN   = 2;
    localparam int M_LOSE  = 3;

    logic clk_36MHz = 1'b0;
    logic reset     = 1'b1;
    int   checks    = 0;
    int   failures  = 0;

    invaders_grid_if #(.COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W)) bus ();

    invaders_grid #(
        .COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W),
        .TICK_DIV(TICK_DIV), .LAND_LINE(LAND_LINE)
    ) dut (
        .clk_36MHz (clk_36MHz),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_36MHz = ~clk_36MHz;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timed out");
    end

    // ---------------- reference model (game rules, plain integers) ----------------
    int       m_state, mx, ml, mdir, m_level, m_ticks, m_hr, m_hc;
    bit       m_hit;
    bit [N-1:0] m_alive;

    task automatic model_reset();
        m_state = M_IDLE; mx = 0; ml = 0; mdir = 1; m_level = 0; m_ticks = 0;
        m_hit = 0; m_hr = 0; m_hc = 0; m_alive = '1;
    endtask

    // True when the coming MARCH cycle carries a step.
    function automatic bit step_due();
        return ((m_ticks + 1) % (TICK_DIV * (8 - m_level))) == 0;
    endfunction

    function automatic bit at_edge();
        return (mdir > 0) ? (mx + COLS - 1 == (1 << X_W) - 1) : (mx == 0);
    endfunction

    task automatic model_step();
        int bx, by;
        bit stepped;
        m_hit = 0;
        if (m_state != M_MARCH) begin
            if (bus.start) begin
                m_alive = '1; mx = 0; ml = 0; mdir = 1; m_ticks = 0;
                m_level = int'(bus.level); m_state = M_MARCH;
            end
            return;
        end
        bx = int'(bus.bullet_x);
        by = int'(bus.bullet_y);
        if (bus.bullet_valid && bx >= mx && bx < mx + COLS && by >= ml && by < ml + ROWS
            && m_alive[(by - ml) * COLS + (bx - mx)]) begin
            m_alive[(by - ml) * COLS + (bx - mx)] = 1'b0;
            m_hit = 1; m_hr = by - ml; m_hc = bx - mx;
        end
        stepped = step_due();
        m_ticks++;
        if (stepped) begin
            if (at_edge()) begin
                ml++; mdir = -mdir;
            end else begin
                mx += mdir;
            end
        end
        if (m_hit && m_alive == '0) m_state = M_WIN;
        else if (stepped && ml + ROWS - 1 == LAND_LINE) m_state = M_LOSE;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        if (reset) model_reset();
        else model_step();
        @(posedge clk_36MHz);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.bullet_valid = 1'b0; bus.bullet_x = '0; bus.bullet_y = '0;
    endtask

    task automatic shoot(input int c, input int r);
        bus.bullet_valid = 1'b1;
        bus.bullet_x = X_W'(mx + c);
        bus.bullet_y = Y_W'(ml + r);
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_hit"},     64'(bus.hit),            64'(m_hit));
        check({tag, "_hitrow"},  64'(bus.hit_row),        64'(m_hr));
        check({tag, "_hitcol"},  64'(bus.hit_col),        64'(m_hc));
        check({tag, "_array"},   64'(bus.invaders_array), 64'(m_alive));
        check({tag, "_x"},       64'(bus.invaders_x),     64'(mx));
        check({tag, "_line"},    64'(bus.invaders_line),  64'(ml));
        check({tag, "_running"}, 64'(bus.running),        64'(m_state == M_MARCH));
        check({tag, "_cleared"}, 64'(bus.cleared),        64'(m_state == M_WIN));
        check({tag, "_landed"},  64'(bus.landed),         64'(m_state == M_LOSE));
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         start;
        logic [2:0]   level;
        logic         bv;
        logic [X_W-1:0] bx;
        logic [Y_W-1:0] by;
        logic         e_hit;
        logic [1:0]   e_row;
        logic [3:0]   e_col;
        logic [X_W-1:0] e_x;
        logic [Y_W-1:0] e_line;
        logic [N-1:0] e_array;
        logic         e_running;
    } vec_t;

    vec_t vecs[12];

    initial begin
        idle_inputs();
        bus.level = '0;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset values.
        check("rst_array",   64'(bus.invaders_array), 64'h3FFFFFFF);
        check("rst_x",       64'(bus.invaders_x),     64'd0);
        check("rst_line",    64'(bus.invaders_line),  64'd0);
        check("rst_running", 64'(bus.running),        64'd0);
        check("rst_cleared", 64'(bus.cleared),        64'd0);
        check("rst_landed",  64'(bus.landed),         64'd0);
        check("rst_hit",     64'(bus.hit),            64'd0);
        check("rst_hitrow",  64'(bus.hit_row),        64'd0);
        check("rst_hitcol",  64'(bus.hit_col),        64'd0);

        // start, level, bv, bx, by | hit, row, col, x, line, array, running
        vecs[0]  = '{1'b1, 3'd0, 1'b0, 5'd0,  4'd0, 1'b0, 2'd0, 4'd0, 5'd0, 4'd0, 30'h3FFFFFFF, 1'b1};
        vecs[1]  = '{1'b0, 3'd0, 1'b1, 5'd3,  4'd1, 1'b1, 2'd1, 4'd3, 5'd0, 4'd0, 30'h3FFFDFFF, 1'b1};
        vecs[2]  = '{1'b0, 3'd0, 1'b1, 5'd3,  4'd1, 1'b0, 2'd1, 4'd3, 5'd0, 4'd0, 30'h3FFFDFFF, 1'b1};
        vecs[3]  = '{1'b0, 3'd0, 1'b1, 5'd15, 4'd0, 1'b0, 2'd1, 4'd3, 5'd0, 4'd0, 30'h3FFFDFFF, 1'b1};
        vecs[4]  = '{1'b0, 3'd0, 1'b1, 5'd9,  4'd2, 1'b1, 2'd2, 4'd9, 5'd0, 4'd0, 30'h1FFFDFFF, 1'b1};
        vecs[5]  = '{1'b0, 3'd0, 1'b1, 5'd10, 4'd0, 1'b0, 2'd2, 4'd9, 5'd0, 4'd0, 30'h1FFFDFFF, 1'b1};
        vecs[6]  = '{1'b0, 3'd0, 1'b1, 5'd5,  4'd3, 1'b0, 2'd2, 4'd9, 5'd0, 4'd0, 30'h1FFFDFFF, 1'b1};
        vecs[7]  = '{1'b1, 3'd7, 1'b0, 5'd0,  4'd0, 1'b0, 2'd2, 4'd9, 5'd0, 4'd0, 30'h1FFFDFFF, 1'b1};
        vecs[8]  = '{1'b0, 3'd0, 1'b0, 5'd0,  4'd0, 1'b0, 2'd2, 4'd9, 5'd1, 4'd0, 30'h1FFFDFFF, 1'b1};
        vecs[9]  = '{1'b0, 3'd0, 1'b1, 5'd0,  4'd0, 1'b0, 2'd2, 4'd9, 5'd1, 4'd0, 30'h1FFFDFFF, 1'b1};
        vecs[10] = '{1'b0, 3'd0, 1'b1, 5'd10, 4'd0, 1'b1, 2'd0, 4'd9, 5'd1, 4'd0, 30'h1FFFDDFF, 1'b1};
        vecs[11] = '{1'b0, 3'd0, 1'b1, 5'd1,  4'd0, 1'b1, 2'd0, 4'd0, 5'd1, 4'd0, 30'h1FFFDDFE, 1'b1};

        for (int i = 0; i < 12; i++) begin
            bus.start        = vecs[i].start;
            bus.level        = vecs[i].level;
            bus.bullet_valid = vecs[i].bv;
            bus.bullet_x     = vecs[i].bx;
            bus.bullet_y     = vecs[i].by;
            cycle();
            check($sformatf("v%0d_hit", i),     64'(bus.hit),            64'(vecs[i].e_hit));
            check($sformatf("v%0d_hitrow", i),  64'(bus.hit_row),        64'(vecs[i].e_row));
            check($sformatf("v%0d_hitcol", i),  64'(bus.hit_col),        64'(vecs[i].e_col));
            check($sformatf("v%0d_x", i),       64'(bus.invaders_x),     64'(vecs[i].e_x));
            check($sformatf("v%0d_line", i),    64'(bus.invaders_line),  64'(vecs[i].e_line));
            check($sformatf("v%0d_array", i),   64'(bus.invaders_array), 64'(vecs[i].e_array));
            check($sformatf("v%0d_running", i), 64'(bus.running),        64'(vecs[i].e_running));
        end

        // Fast march: right to the edge, descend, turn left.
        do_reset();
        bus.start = 1'b1; bus.level = 3'd7;
        cycle();
        bus.start = 1'b0;
        check("fast_start_x", 64'(bus.invaders_x), 64'd0);
        for (int k = 1; k <= 22; k++) begin
            cycle();
            check($sformatf("fast_x%0d", k), 64'(bus.invaders_x), 64'(k));
            check($sformatf("fast_l%0d", k), 64'(bus.invaders_line), 64'd0);
        end
        cycle();
        check("fast_descend_line", 64'(bus.invaders_line), 64'd1);
        check("fast_descend_x",    64'(bus.invaders_x),    64'd22);
        cycle();
        check("fast_left_x",       64'(bus.invaders_x),    64'd21);
        check("fast_left_line",    64'(bus.invaders_line), 64'd1);

        // Keep marching to the landing line.
        for (int k = 0; k < 2000 && !bus.landed; k++) begin
            cycle();
            compare_model("march");
        end
        check("land_landed",  64'(bus.landed),        64'd1);
        check("land_line",    64'(bus.invaders_line), 64'd12);
        check("land_running", 64'(bus.running),       64'd0);
        for (int k = 0; k < 5; k++) begin
            shoot(0, 0);
            cycle();
            compare_model("lose_frozen");
        end
        check("lose_array_intact", 64'(bus.invaders_array), 64'h3FFFFFFF);

        // Restart from LOSE, then reset mid-MARCH.
        idle_inputs();
        bus.start = 1'b1; bus.level = 3'd3;
        cycle();
        bus.start = 1'b0;
        compare_model("restart");
        shoot(0, 0);
        cycle();
        idle_inputs();
        for (int k = 0; k < 11; k++) cycle();
        compare_model("pre_reset");
        check("pre_reset_x", 64'(bus.invaders_x), 64'd2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst_running", 64'(bus.running),        64'd0);
        check("midrst_array",   64'(bus.invaders_array), 64'h3FFFFFFF);
        check("midrst_x",       64'(bus.invaders_x),     64'd0);
        check("midrst_line",    64'(bus.invaders_line),  64'd0);
        check("midrst_hit",     64'(bus.hit),            64'd0);
        check("midrst_hitrow",  64'(bus.hit_row),        64'd0);
        check("midrst_hitcol",  64'(bus.hit_col),        64'd0);
        cycle();
        check("midrst_idle_x",  64'(bus.invaders_x),     64'd0);

        // Destroy the whole wave.
        bus.start = 1'b1; bus.level = 3'd0;
        cycle();
        bus.start = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                shoot(c, r);
                cycle();
                check($sformatf("clear_hit_r%0dc%0d", r, c), 64'(bus.hit), 64'd1);
            end
        end
        check("clear_cleared", 64'(bus.cleared),        64'd1);
        check("clear_running", 64'(bus.running),        64'd0);
        check("clear_array",   64'(bus.invaders_array), 64'd0);
        for (int k = 0; k < 10; k++) begin
            shoot(k % COLS, k % ROWS);
            cycle();
            compare_model("win_frozen");
        end
        idle_inputs();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        check("rewave_array",   64'(bus.invaders_array), 64'h3FFFFFFF);
        check("rewave_running", 64'(bus.running),        64'd1);
        check("rewave_cleared", 64'(bus.cleared),        64'd0);

        // Last invader destroyed on the same cycle as the landing step.
        begin
            bit shot;
            shot = 0;
            do_reset();
            bus.start = 1'b1; bus.level = 3'd7;
            cycle();
            bus.start = 1'b0;
            for (int i = 0; i < N - 1; i++) begin
                shoot(i % COLS, i / COLS);
                cycle();
            end
            idle_inputs();
            for (int k = 0; k < 2000 && !shot && m_state == M_MARCH; k++) begin
                if (step_due() && at_edge() && ml + ROWS == LAND_LINE) begin
                    shoot(COLS - 1, ROWS - 1);
                    shot = 1;
                end
                cycle();
                idle_inputs();
            end
            check("prio_reached",  64'(shot),               64'd1);
            check("prio_cleared",  64'(bus.cleared),        64'd1);
            check("prio_landed",   64'(bus.landed),         64'd0);
            check("prio_line",     64'(bus.invaders_line),  64'd12);
            compare_model("prio");
        end

        // Random play against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 399) == 0);
            bus.level = 3'($urandom_range(0, 7));
            bus.start = (m_state != M_MARCH) ? ($urandom_range(0, 7) == 0)
                                             : ($urandom_range(0, 31) == 0);
            bus.bullet_valid = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                bus.bullet_x = X_W'($urandom_range(0, (1 << X_W) - 1));
                bus.bullet_y = Y_W'($urandom_range(0, (1 << Y_W) - 1));
            end else begin
                bus.bullet_x = X_W'(mx + $urandom_range(0, COLS + 1) - 1);
                bus.bullet_y = Y_W'(ml + $urandom_range(0, ROWS + 1) - 1);
            end
            cycle();
            compare_model("rand");
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/invaders_grid.md
INVADERS_GRID -- requirements
Module: invaders_grid

Interface
REQ-001 Parameter COLS, default 10, invader columns per row.
REQ-002 Parameter ROWS, default 3, invader rows.
REQ-003 Parameter X_W, default 5, screen column coordinate width.
REQ-004 Parameter Y_W, default 4, screen line coordinate width.
REQ-005 Parameter TICK_DIV, default 1, clock cycles per base tick (1 = simulation speed).
REQ-006 Parameter LAND_LINE, default 14, screen line whose occupation by the bottom row ends the game.
REQ-007 clk_36MHz  in  1  single clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  begin or restart a wave; level-sampled.
REQ-010 level  in  3  speed level, latched on accepted start.
REQ-011 bullet_valid  in  1  bullet_x/bullet_y are valid this cycle.
REQ-012 bullet_x  in  X_W, bullet_y  in  Y_W  bullet screen position.
REQ-013 hit  out  1  one-cycle pulse when a live invader is destroyed.
REQ-014 hit_row  out  clog2(ROWS), hit_col  out  clog2(COLS)  destroyed invader's position; valid with hit, hold otherwise.
REQ-015 invaders_array  out  ROWS*COLS  alive flags; bit r*COLS+c, row 0 top, col 0 leftmost.
REQ-016 invaders_x  out  X_W  screen column of grid col 0; invaders_line  out  Y_W  screen line of grid row 0.
REQ-017 running, cleared, landed  out  1 each  FSM in MARCH, WIN, LOSE respectively.

Function
REQ-018 FSM states IDLE, MARCH, WIN, LOSE; start in IDLE/WIN/LOSE -> MARCH; start in MARCH ignored.
REQ-019 Accepted start loads array all-ones, x=0, line=0, direction right, clears tick/step counters, latches level.
REQ-020 Tick counter pulses every TICK_DIV cycles in MARCH; step occurs every (8 - latched level) ticks (level 0 -> 8, level 7 -> 1).
REQ-021 Step, direction right: if x+COLS-1 == 2^X_W-1 then line+1 and direction left, else x+1; direction left: if x==0 then line+1 and direction right, else x-1; x unchanged on descent.
REQ-022 Grid extent is always the full COLS x ROWS regardless of destroyed columns.
REQ-023 In MARCH, bullet_valid with bullet_x in [x, x+COLS-1], bullet_y in [line, line+ROWS-1] and the addressed bit set clears that bit and asserts hit, hit_row, hit_col on the next cycle.
REQ-024 Hit test uses position registers of the bullet_valid cycle, even if a step occurs that same cycle.
REQ-025 Bullet on a dead invader, outside the grid, or outside MARCH: no hit, no state change.
REQ-026 Array all-zero after a hit -> WIN next cycle; WIN takes priority over a simultaneous landing.
REQ-027 Step making line+ROWS-1 == LAND_LINE -> LOSE next cycle; no further movement or hits in WIN/LOSE.
REQ-028 Position, array and counters hold in IDLE, WIN, LOSE.

Reset
REQ-029 reset at any time, including mid-MARCH, forces IDLE, array all-ones, x=0, line=0, direction right, counters 0, latched level 0.
REQ-030 Reset values: hit=0, hit_row=0, hit_col=0, running=0, cleared=0, landed=0.

Structure
REQ-031 Shared package holds FSM state encoding, direction encoding and default parameter constants.
REQ-032 One sub-module invaders_tick (TICK_DIV divider plus level-based step counter) outputs step pulse.
REQ-033 Elaboration check: COLS <= 2^X_W, ROWS <= LAND_LINE < 2^Y_W.

Verification (defaults, TICK_DIV=1)
REQ-034 Reset -> invaders_array=30'h3FFFFFFF, x=0, line=0, running=0, hit=0.
REQ-035 start, level=7 -> x increments each cycle to 22; next step line=1, x=22; following step x=21.
REQ-036 level=0, x=0, line=0, bullet_valid x=3 y=1 -> next cycle hit=1, hit_row=1, hit_col=3, bit 13 cleared; repeat -> no hit.
REQ-037 bullet_valid x=15 y=0 at x=0 -> no hit, array unchanged.
REQ-038 Destroy all 30 invaders -> cleared=1, running=0, x/line frozen; start -> array all-ones, running=1.
REQ-039 level=7, no bullets -> landed=1 when line reaches 12; reset mid-MARCH -> IDLE with reset values next cycle.
